// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache with byte-serial line refill
// Hits answer on the cycle after acceptance; misses refill a 16-byte line one byte per mc_valid.
module icache #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  output logic        ic_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_valid,
  input  logic [7:0]  mc_byte
);
  localparam int LINE_BYTES = 16;
  localparam int LINE_W     = LINE_BYTES * 8;
  localparam int LINES      = 1 << INDEX_BITS;
  localparam int TAG_BITS   = 28 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;
  state_t state, state_nxt;

  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tag_arr  [LINES];
  logic [LINE_W-1:0]     data_arr [LINES];
  logic [LINE_W-9:0]     line_buf;

  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] req_idx;
  logic [1:0]            req_word;
  logic [3:0]            cnt;
  logic                  drop;
  logic                  iv_q;

  logic [TAG_BITS-1:0]   pc_tag;
  logic [INDEX_BITS-1:0] pc_idx;
  logic                  accept;
  logic                  hit;
  logic                  byte_take;
  logic                  fill_last;
  logic [LINE_W-1:0]     fill_line;
  logic                  unused_pc;

  function automatic logic [31:0] word_of(input logic [LINE_W-1:0] line, input logic [1:0] w);
    logic [31:0] r;
    case (w)
      2'd0:    r = line[31:0];
      2'd1:    r = line[63:32];
      2'd2:    r = line[95:64];
      default: r = line[127:96];
    endcase
    return r;
  endfunction

  assign pc_tag    = if_pc[31:4+INDEX_BITS];
  assign pc_idx    = if_pc[3+INDEX_BITS:4];
  assign unused_pc = ^if_pc[1:0];
  assign accept    = rdy && if_valid && (state == IDLE) && !clear;
  assign hit       = valid[pc_idx] && (tag_arr[pc_idx] == pc_tag);
  assign byte_take = rdy && (state == REFILL) && mc_valid;
  assign fill_last = byte_take && (cnt == 4'd15);
  // The last byte bypasses the buffer so the line installs on the edge that consumes it.
  assign fill_line = {mc_byte, line_buf};

  assign ic_ready    = (state == IDLE);
  assign mc_req      = (state == REFILL);
  // A flush arriving alongside a hit response suppresses it.
  assign instr_valid = iv_q && !(clear && (state == IDLE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else if (rdy) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !hit) state_nxt = REFILL;
      REFILL:  if (fill_last) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid    <= '0;
      cnt      <= 4'd0;
      drop     <= 1'b0;
      iv_q     <= 1'b0;
      instr    <= 32'd0;
      mc_addr  <= 32'd0;
      req_tag  <= '0;
      req_idx  <= '0;
      req_word <= 2'd0;
    end else if (rdy) begin
      iv_q <= 1'b0;
      if (accept) begin
        req_tag  <= pc_tag;
        req_idx  <= pc_idx;
        req_word <= if_pc[3:2];
        if (hit) begin
          iv_q  <= 1'b1;
          instr <= word_of(data_arr[pc_idx], if_pc[3:2]);
        end else begin
          mc_addr <= {pc_tag, pc_idx, 4'b0000};
          cnt     <= 4'd0;
        end
      end
      if ((state == REFILL) && clear) drop <= 1'b1;
      if (byte_take) cnt <= cnt + 4'd1;
      if (fill_last) begin
        valid[req_idx] <= 1'b1;
        mc_addr        <= 32'd0;
        iv_q           <= !(drop || clear);
        instr          <= word_of(fill_line, req_word);
      end
      if (state == RESP) drop <= 1'b0;
    end
  end

  // Storage arrays carry no reset; the valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (byte_take) begin
      for (int b = 0; b < LINE_BYTES - 1; b++) begin
        if (cnt == 4'(b)) line_buf[b*8 +: 8] <= mc_byte;
      end
    end
    if (fill_last) begin
      data_arr[req_idx] <= fill_line;
      tag_arr[req_idx]  <= req_tag;
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - randomized self-checking bench for icache
// A line-level model of valid/tag per index plus a fixed memory image predicts every response.
module tb_icache;
  logic        clk;
  logic        rst;
  logic        rdy;
  logic        clear;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        ic_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_valid;
  logic [7:0]  mc_byte;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mvalid;
  logic [23:0] mtag [16];

  icache #(.INDEX_BITS(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .if_valid(if_valid), .if_pc(if_pc), .ic_ready(ic_ready),
    .instr_valid(instr_valid), .instr(instr), .mc_req(mc_req),
    .mc_addr(mc_addr), .mc_valid(mc_valid), .mc_byte(mc_byte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ {a[11:8], 4'h0} ^ a[23:16];
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    logic [31:0] a;
    a = {pc[31:2], 2'b00};
    return {mem_byte(a + 3), mem_byte(a + 2), mem_byte(a + 1), mem_byte(a)};
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return mvalid[pc[7:4]] && (mtag[pc[7:4]] == pc[31:8]);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ic_ready"}, ic_ready, 1);
    check({tag, "_instr_valid"}, instr_valid, 0);
    check({tag, "_instr"}, instr, 0);
    check({tag, "_mc_req"}, mc_req, 0);
    check({tag, "_mc_addr"}, mc_addr, 0);
  endtask

  // One fetch transaction; clr_at/stall_at/rst_at name the refill byte after which the event occurs.
  task automatic do_fetch(input logic [31:0] pc, input int clr_at, input int stall_at, input int rst_at);
    logic [31:0] base;
    logic [31:0] expw;
    bit          dropped;
    base    = {pc[31:4], 4'h0};
    expw    = mem_word(pc);
    dropped = 0;
    check("ready_before", ic_ready, 1);
    if_valid = 1'b1;
    if_pc    = pc;
    if (model_hit(pc)) begin
      tick();
      if_valid = 1'b0;
      if_pc    = $urandom;
      check("hit_valid", instr_valid, 1);
      check("hit_instr", instr, expw);
      check("hit_no_req", mc_req, 0);
      tick();
      check("hit_single_pulse", instr_valid, 0);
      return;
    end
    tick();
    if_valid = 1'b0;
    if_pc    = $urandom;
    check("miss_req", mc_req, 1);
    check("miss_addr", mc_addr, base);
    check("miss_busy", ic_ready, 0);
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        tick();
        check("gap_req", mc_req, 1);
        check("gap_no_valid", instr_valid, 0);
      end
      mc_valid = 1'b1;
      mc_byte  = mem_byte(base + 32'(k));
      check("refill_addr", mc_addr, base);
      tick();
      mc_valid = 1'b0;
      mc_byte  = 8'($urandom);
      if (k == 15) break;
      check("refill_req_held", mc_req, 1);
      check("refill_no_valid", instr_valid, 0);
      if (k == rst_at) begin
        #2 rst = 1'b0;
        #1 check_reset_outputs("async_rst");
        mvalid = '0;
        #1 rst = 1'b1;
        return;
      end
      if (k == clr_at) begin
        clear = 1'b1;
        tick();
        clear   = 1'b0;
        dropped = 1;
        check("clear_req_held", mc_req, 1);
      end
      if (k == stall_at) begin
        rdy = 1'b0;
        repeat (5) begin
          tick();
          check("stall_req", mc_req, 1);
          check("stall_addr", mc_addr, base);
          check("stall_no_valid", instr_valid, 0);
        end
        rdy = 1'b1;
      end
    end
    mvalid[pc[7:4]] = 1'b1;
    mtag[pc[7:4]]   = pc[31:8];
    check("resp_valid", instr_valid, dropped ? 0 : 1);
    if (!dropped) check("resp_instr", instr, expw);
    check("resp_req_low", mc_req, 0);
    check("resp_addr_zero", mc_addr, 0);
    check("resp_busy", ic_ready, 0);
    tick();
    check("after_resp_ready", ic_ready, 1);
    check("after_resp_no_valid", instr_valid, 0);
  endtask

  task automatic back_to_back(input logic [31:0] pa, input logic [31:0] pb);
    if_valid = 1'b1;
    if_pc    = pa;
    tick();
    if_pc = pb;
    check("b2b_first_valid", instr_valid, 1);
    check("b2b_first_instr", instr, mem_word(pa));
    check("b2b_ready", ic_ready, 1);
    tick();
    if_valid = 1'b0;
    check("b2b_second_valid", instr_valid, 1);
    check("b2b_second_instr", instr, mem_word(pb));
    tick();
    check("b2b_end", instr_valid, 0);
  endtask

  task automatic clear_kills_hit(input logic [31:0] pc);
    if_valid = 1'b1;
    if_pc    = pc;
    tick();
    if_valid = 1'b0;
    clear    = 1'b1;
    #1 check("clear_kill_hit", instr_valid, 0);
    tick();
    clear = 1'b0;
    check("clear_kill_after", instr_valid, 0);
    check("clear_kill_ready", ic_ready, 1);
  endtask

  task automatic clear_same_cycle(input logic [31:0] pc);
    if_valid = 1'b1;
    if_pc    = pc;
    clear    = 1'b1;
    tick();
    if_valid = 1'b0;
    clear    = 1'b0;
    check("same_clear_no_valid", instr_valid, 0);
    check("same_clear_no_req", mc_req, 0);
    check("same_clear_ready", ic_ready, 1);
  endtask

  initial begin
    logic [31:0] pc;
    int          sel;
    rst      = 1'b0;
    rdy      = 1'b1;
    clear    = 1'b0;
    if_valid = 1'b0;
    if_pc    = 32'd0;
    mc_valid = 1'b0;
    mc_byte  = 8'd0;
    mvalid   = '0;
    for (int i = 0; i < 16; i++) mtag[i] = '0;
    #12 check_reset_outputs("reset");
    #6 rst = 1'b1;
    tick();

    do_fetch(32'h0000_1004, -1, -1, -1);
    do_fetch(32'h0000_1008, -1, -1, -1);
    back_to_back(32'h0000_100C, 32'h0000_1000);
    do_fetch(32'h0000_1100, -1, -1, -1);
    do_fetch(32'h0000_1000, -1, -1, -1);
    do_fetch(32'h0000_2004, 7, -1, -1);
    do_fetch(32'h0000_2004, -1, -1, -1);
    do_fetch(32'h0000_3008, -1, 6, -1);
    clear_kills_hit(32'h0000_3008);
    clear_same_cycle(32'h0000_3008);
    clear_same_cycle(32'h0000_7000);
    do_fetch(32'h0000_4000, -1, -1, 3);
    do_fetch(32'h0000_4000, -1, -1, -1);

    for (int t = 0; t < 80; t++) begin
      pc = (32'($urandom_range(0, 3)) << 16) | (32'($urandom_range(0, 3)) << 8) |
           (32'($urandom_range(0, 3)) << 4) | ($urandom & 32'hF);
      sel = $urandom_range(0, 11);
      if (sel == 0)      do_fetch(pc, $urandom_range(0, 14), -1, -1);
      else if (sel == 1) do_fetch(pc, -1, $urandom_range(0, 14), -1);
      else if (sel == 2) do_fetch(pc, -1, -1, $urandom_range(0, 14));
      else if (sel == 3 && model_hit(pc)) clear_kills_hit(pc);
      else               do_fetch(pc, -1, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
